// File: rtl/sl_tx_if.sv
// Bus bundle for sl_transmitter: config access, word handshake and the two SL line outputs.
interface sl_tx_if;
  logic        wr_enable;
  logic [15:0] wr_config_w;
  logic [15:0] r_config_w;
  logic [31:0] data_w;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic        serial_line_zeroes;
  logic        serial_line_ones;

  modport master (
    output wr_enable, wr_config_w, data_w, tx_start,
    input  r_config_w, tx_busy, tx_done, serial_line_zeroes, serial_line_ones
  );

  modport slave (
    input  wr_enable, wr_config_w, data_w, tx_start,
    output r_config_w, tx_busy, tx_done, serial_line_zeroes, serial_line_ones
  );
endinterface

// File: rtl/sl_transmitter.sv
// SL frame transmitter: 32-bit word sent LSB-first as low pulses, then parity pair and stop marker.
// Define SL_TX_PARITY_INJECT_EN to make config bit [0] invert the transmitted parity pair.
module sl_transmitter #(
  parameter logic [15:0] RESET_CONFIG = 16'h0010
) (
  input logic    clk,
  input logic    rst_n,
  sl_tx_if.slave bus
);

`ifdef SL_TX_PARITY_INJECT_EN
  localparam logic INJ_EN = 1'b1;
`else
  localparam logic INJ_EN = 1'b0;
`endif
  localparam logic [15:0] RST_CFG = {RESET_CONFIG[15:1], RESET_CONFIG[0] & INJ_EN};

  typedef enum logic [3:0] {
    IDLE, BIT_LEAD, BIT_PULSE, BIT_TAIL, PAR_LEAD, PARITY, GAP, STOP, STOP_TAIL
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cfg_q, cfg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  len_q, len_d;
  logic [1:0]  rate_q, rate_d;
  logic [31:0] shift_q, shift_d;
  logic        p0_q, p0_d, p1_q, p1_d;
  logic        sl0_q, sl0_d, sl1_q, sl1_d;
  logic        done_q, done_d;
  logic [5:0]  wr_len;
  logic        wr_ok;
  logic [31:0] mask;
  logic [5:0]  dur;
  logic        last;

  function automatic logic [4:0] half_period(input logic [1:0] rate);
    case (rate)
      2'b00:   half_period = 5'd16;
      2'b01:   half_period = 5'd8;
      default: half_period = 5'd4;
    endcase
  endfunction

  assign wr_len = bus.wr_config_w[6:1];
  assign wr_ok  = !wr_len[0] && (wr_len >= 6'd8) && (wr_len <= 6'd32);
  // Shift by 32 yields zero, so a 32-bit length selects every bit.
  assign mask   = ~(32'hFFFF_FFFF << cfg_q[6:1]);

  always_comb begin
    cfg_d = cfg_q;
    if (bus.wr_enable && wr_ok) cfg_d = {bus.wr_config_w[15:1], bus.wr_config_w[0] & INJ_EN};
  end

  always_comb begin
    dur = {1'b0, half_period(rate_q)};
    if (state_q inside {BIT_PULSE, PARITY, GAP, STOP}) dur = {half_period(rate_q), 1'b0};
    last = ({1'b0, cnt_q} == (dur - 6'd1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    idx_d   = idx_q;
    len_d   = len_q;
    rate_d  = rate_q;
    shift_d = shift_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.tx_start) begin
          state_d = BIT_LEAD;
          shift_d = bus.data_w;
          len_d   = cfg_q[6:1];
          rate_d  = cfg_q[8:7];
          p0_d    = ~(^(~bus.data_w & mask)) ^ cfg_q[0];
          p1_d    = (^(bus.data_w & mask)) ^ cfg_q[0];
        end
      end
      BIT_LEAD:  if (last) begin state_d = BIT_PULSE; cnt_d = '0; end
      BIT_PULSE: if (last) begin state_d = BIT_TAIL;  cnt_d = '0; end
      BIT_TAIL: if (last) begin
        cnt_d   = '0;
        idx_d   = idx_q + 6'd1;
        shift_d = shift_q >> 1;
        state_d = ((idx_q + 6'd1) == len_q) ? PAR_LEAD : BIT_LEAD;
      end
      PAR_LEAD:  if (last) begin state_d = PARITY;    cnt_d = '0; end
      PARITY:    if (last) begin state_d = GAP;       cnt_d = '0; end
      GAP:       if (last) begin state_d = STOP;      cnt_d = '0; end
      STOP:      if (last) begin state_d = STOP_TAIL; cnt_d = '0; end
      STOP_TAIL: if (last) begin state_d = IDLE; cnt_d = '0; done_d = 1'b1; end
      default:   state_d = IDLE;
    endcase

    // Lines are decoded from the next state so they are registered together with it.
    sl0_d = 1'b1;
    sl1_d = 1'b1;
    case (state_d)
      BIT_PULSE: if (shift_d[0]) sl1_d = 1'b0; else sl0_d = 1'b0;
      PARITY:    begin sl0_d = p0_d; sl1_d = p1_d; end
      STOP:      begin sl0_d = 1'b0; sl1_d = 1'b0; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      cfg_q   <= RST_CFG;
      sl0_q   <= 1'b1;
      sl1_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
      sl0_q   <= sl0_d;
      sl1_q   <= sl1_d;
      done_q  <= done_d;
    end
  end

  // Frame snapshot: only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    len_q   <= len_d;
    rate_q  <= rate_d;
    p0_q    <= p0_d;
    p1_q    <= p1_d;
  end

  assign bus.r_config_w         = cfg_q;
  assign bus.tx_busy            = (state_q != IDLE);
  assign bus.tx_done            = done_q;
  assign bus.serial_line_zeroes = sl0_q;
  assign bus.serial_line_ones   = sl1_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// Scoreboard bench for sl_transmitter: frames are modelled as timed line events and matched by a line monitor.
module tb_sl_transmitter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   abort_cnt = 0;
  int   abort_seen = 0;
  logic [15:0] cfg_model = 16'h0010;

  typedef struct {
    int         kind;   // 0 = non-idle line run, 1 = tx_done
    logic [1:0] pat;    // {SL0, SL1} during the run; {busy, 0} for done
    int         st;     // start cycle relative to busy rising
    int         len;
  } ev_t;
  ev_t exp_q[$];

  sl_tx_if bus ();
  sl_transmitter #(.RESET_CONFIG(16'h0010)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int half_of(input logic [15:0] c);
    case (c[8:7])
      2'd0:    return 16;
      2'd1:    return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] cfg_after_write(input logic [15:0] cur, input logic [15:0] w);
    int len;
    len = 32'(w[6:1]);
    if ((len % 2) != 0 || len < 8 || len > 32) return cur;
`ifdef SL_TX_PARITY_INJECT_EN
    return w;
`else
    return w & 16'hFFFE;
`endif
  endfunction

  task automatic push_frame(input logic [15:0] c, input logic [31:0] d);
    int h, len, zeros, ones;
    logic p0, p1;
    ev_t e;
    h = half_of(c);
    len = 32'(c[6:1]);
    zeros = 0;
    ones = 0;
    for (int i = 0; i < len; i++) begin
      e.kind = 0;
      e.st   = 4 * h * i + h;
      e.len  = 2 * h;
      e.pat  = d[i] ? 2'b10 : 2'b01;
      exp_q.push_back(e);
      if (d[i]) ones++; else zeros++;
    end
    p0 = ((zeros % 2) == 0);
    p1 = ((ones % 2) == 1);
`ifdef SL_TX_PARITY_INJECT_EN
    if (c[0]) begin p0 = !p0; p1 = !p1; end
`endif
    e.kind = 0; e.st = 4 * h * len + h;     e.len = 2 * h; e.pat = {p0, p1}; exp_q.push_back(e);
    e.kind = 0; e.st = 4 * h * len + 5 * h; e.len = 2 * h; e.pat = 2'b00;    exp_q.push_back(e);
    e.kind = 1; e.st = 4 * h * len + 8 * h; e.len = 0;     e.pat = 2'b00;    exp_q.push_back(e);
  endtask

  task automatic match_event(input ev_t g);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind=%0d pat=%b st=%0d len=%0d, expected no event", g.kind, g.pat, g.st, g.len);
      return;
    end
    e = exp_q.pop_front();
    if (g.kind != e.kind || g.pat != e.pat || g.st != e.st || g.len != e.len) begin
      errors++;
      $display("FAIL event: got kind=%0d pat=%b st=%0d len=%0d, expected kind=%0d pat=%b st=%0d len=%0d",
               g.kind, g.pat, g.st, g.len, e.kind, e.pat, e.st, e.len);
    end
  endtask

  // Line monitor: turns SL activity into timed runs and matches them against the scoreboard.
  int         fcyc = 0;
  logic       busy_prev = 1'b0;
  logic       run_on = 1'b0;
  logic [1:0] run_pat = 2'b11;
  int         run_st = 0;
  always @(negedge clk) begin
    logic [1:0] pat;
    ev_t got;
    if (abort_cnt != abort_seen) begin
      abort_seen = abort_cnt;
      exp_q.delete();
      run_on = 1'b0;
    end
    pat = {bus.serial_line_zeroes, bus.serial_line_ones};
    if (bus.tx_busy && !busy_prev) fcyc = 0; else fcyc++;
    busy_prev = bus.tx_busy;
    if (run_on && pat != run_pat) begin
      got.kind = 0; got.pat = run_pat; got.st = run_st; got.len = fcyc - run_st;
      match_event(got);
      run_on = 1'b0;
    end
    if (!run_on && pat != 2'b11) begin
      run_on = 1'b1; run_pat = pat; run_st = fcyc;
    end
    if (bus.tx_done) begin
      got.kind = 1; got.pat = {bus.tx_busy, 1'b0}; got.st = fcyc; got.len = 0;
      match_event(got);
    end
  end

  task automatic cfg_write(input logic [15:0] w);
    @(posedge clk); #1;
    bus.wr_enable = 1'b1;
    bus.wr_config_w = w;
    cfg_model = cfg_after_write(cfg_model, w);
    @(posedge clk); #1;
    bus.wr_enable = 1'b0;
    bus.wr_config_w = 16'h0;
    chk("r_config_w", 32'(bus.r_config_w), 32'(cfg_model));
  endtask

  task automatic send(input logic [31:0] d, input int hold);
    int guard;
    guard = 0;
    while (bus.tx_busy === 1'b1 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) begin
      checks++; errors++;
      $display("FAIL send_wait: busy still 1 after %0d cycles, expected 0", guard);
    end
    bus.tx_start = 1'b1;
    bus.data_w = d;
    push_frame(cfg_model, d);
    @(posedge clk); #1;
    chk("busy_after_start", 32'(bus.tx_busy), 32'd1);
    for (int k = 0; k < hold; k++) begin @(posedge clk); #1; end
    bus.tx_start = 1'b0;
    bus.data_w = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.tx_done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_done: tx_done=0 after %0d cycles, expected 1", budget);
    end
  endtask

  initial begin
    bus.wr_enable = 1'b0;
    bus.wr_config_w = 16'h0;
    bus.data_w = 32'h0;
    bus.tx_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sl0", 32'(bus.serial_line_zeroes), 32'd1);
    chk("reset_sl1", 32'(bus.serial_line_ones), 32'd1);
    chk("reset_busy", 32'(bus.tx_busy), 32'd0);
    chk("reset_done", 32'(bus.tx_done), 32'd0);
    chk("reset_cfg", 32'(bus.r_config_w), 32'h0010);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h0000_00A5, 0);
    wait_done(2000);

    cfg_write(16'h0140);
    send(32'hFFFF_FFFF, 0);
    wait_done(2000);

    // Start held during a frame, plus a config write that only affects the next frame.
    cfg_write(16'h0010);
    send($urandom, 20);
    cfg_write(16'h00A0);
    chk("busy_during_write", 32'(bus.tx_busy), 32'd1);
    wait_done(2000);
    send($urandom, 0);
    wait_done(2000);

    cfg_write(16'h0013);
    cfg_write(16'h0042);

    cfg_write(16'h0011);
    send(32'h0, 0);
    wait_done(2000);

    // Asynchronous reset in the middle of the first pulse.
    cfg_write(16'h0110);
    send(32'h0000_005A, 0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    abort_cnt++;
    #1;
    chk("abort_sl0", 32'(bus.serial_line_zeroes), 32'd1);
    chk("abort_sl1", 32'(bus.serial_line_ones), 32'd1);
    chk("abort_busy", 32'(bus.tx_busy), 32'd0);
    rst_n = 1'b1;
    cfg_model = 16'h0010;
    repeat (30) @(posedge clk);
    #1;
    chk("after_reset_cfg", 32'(bus.r_config_w), 32'h0010);
    chk("after_reset_busy", 32'(bus.tx_busy), 32'd0);
    send($urandom, 0);
    wait_done(2000);

    for (int it = 0; it < 12; it++) begin
      int len, rate, inj;
      len  = 2 * $urandom_range(4, 16);
      rate = $urandom_range(1, 3);
      inj  = $urandom_range(0, 1);
      cfg_write(16'((rate << 7) | (len << 1) | inj));
      send($urandom, $urandom_range(0, 3));
      wait_done(3000);
      send($urandom, 0);
      wait_done(3000);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sl_transmitter.md
# sl_transmitter

Serial-line (SL) frame transmitter that drives the two-wire idle-high SL bus (zeroes line / ones line) consumed by `SlReceiver`. It accepts a 32-bit word over a start/busy handshake and serialises it LSB-first. Each bit is a low pulse on the line matching its value, followed by the parity pair and the stop marker. Length and bit rate come from a config register with the same layout and access style as the receiver's.

## Interface
Parameters:
- `RESET_CONFIG`, 16'h0010: config register reset value (length 8, rate 00, inject off).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `wr_enable`  in  1  config write strobe, one cycle.
- `wr_config_w`  in  16  config write data. Fields:
  - [0] parity-inject.
  - [6:1] word length.
  - [8:7] rate.
  - others reserved, written 0.
- `r_config_w`  out  16  config readback.
- `data_w`  in  32  word to send; bits above length ignored.
- `tx_start`  in  1  start request, sampled on `clk`.
- `tx_busy`  out  1  frame in progress.
- `tx_done`  out  1  one-cycle pulse at end of frame.
- `serial_line_zeroes`  out  1  SL0, idle 1.
- `serial_line_ones`  out  1  SL1, idle 1.

## Operation
- Half-period H in clk cycles from rate field:
  - 00 → 16
  - 01 → 8
  - 10 → 4
  - 11 → 4 (reserved, aliases 10)
- Config write, accepted any cycle including while busy:
  - Rejected, register unchanged, when length is odd, <8 or >32.
  - Otherwise all fields are stored.
  - A frame uses the config snapshot latched when its start is accepted.
- Start accepted when `tx_start`=1 and `tx_busy`=0. `data_w` and config are latched in that cycle. `tx_start` while busy is ignored, with no queueing.
- FSM states:
  - IDLE: both lines 1.
  - BIT_LEAD: 1H, both lines 1.
  - BIT_PULSE: 2H. SL0=0 if the current bit is 0, else SL1=0; the other line stays 1.
  - BIT_TAIL: 1H, both lines 1. Bit index increments; returns to BIT_LEAD until index = length, then goes to PAR_LEAD.
  - PAR_LEAD: 1H, both lines 1.
  - PARITY: 2H, SL0=p0, SL1=p1.
  - GAP: 2H, both lines 1.
  - STOP: 2H, both lines 0.
  - STOP_TAIL: 1H, both lines 1, then IDLE.
- Parity arithmetic:
  - p0 = 1 XOR (number of 0 bits mod 2).
  - p1 = (number of 1 bits mod 2).
  - Both are computed over exactly `length` bits.
- Frame duration is 4H·length + 8H cycles.
- All line outputs are registered, with no combinational path from inputs.

## Timing
- Reset values (asynchronous):
  - `serial_line_zeroes`=1, `serial_line_ones`=1.
  - `tx_busy`=0, `tx_done`=0.
  - `r_config_w`=RESET_CONFIG.
  - FSM in IDLE, counters 0.
- Start accepted at edge E: `tx_busy`=1 from E+1. Frame cycle 0 is E+1, the first BIT_LEAD cycle.
- First pulse is low during frame cycles H..3H-1.
- `tx_done`=1 and `tx_busy`=0 in the cycle after the last STOP_TAIL cycle.
- A start asserted in the `tx_done` cycle is accepted, giving back-to-back frames with no idle gap beyond STOP_TAIL.
- Config readback reflects a write from the cycle after `wr_enable`.
- `rst_n` low mid-frame: lines return to 1 immediately and the frame is abandoned. After release the block is in IDLE and needs a new start.

## Configuration
- Macro `SL_TX_PARITY_INJECT_EN`.
  - Defined: config bit [0] is stored. When set, a frame drives SL0=~p0 and SL1=~p1 in PARITY, for receiver parity-error testing.
  - Undefined: bit [0] is not stored, reads back 0, and parity is always correct.

## Test plan
- Config 0x0010 (len 8, H=16), data 0x000000A5, start:
  - pulse order SL1,SL0,SL1,SL0,SL0,SL1,SL0,SL1;
  - PARITY SL0=1, SL1=0; STOP both 0;
  - `tx_done` 640 cycles after busy rises.
- Config 0x0140 (len 32, rate 10, H=4), data 0xFFFFFFFF:
  - SL0 stays 1 until STOP; PARITY SL0=1, SL1=0;
  - frame 544 cycles.
- Start held high during a frame, plus config write 0x00A0 mid-frame:
  - second start ignored; current frame stays len 8;
  - `r_config_w`=0x00A0 next cycle; next frame uses len 16, rate 01.
- Write 0x0013 (len 9), then 0x0042 (len 33):
  - both rejected; `r_config_w` unchanged.
- `rst_n` pulsed low mid-BIT_PULSE:
  - both lines 1 and busy 0 during reset without a clock edge;
  - no `tx_done`; next start produces a full correct frame.
- With `SL_TX_PARITY_INJECT_EN`, config 0x0011, data 0x00:
  - PARITY SL0=0, SL1=1.
  - Loopback into `SlReceiver` with PCE=1 reports parity error status and keeps the previous word.
